// File: rtl/pipelined_controller.sv
// Decode/Execute control unit for the RV32I(+M) pipeline: decodes into a registered
// Execute control word, resolves branches, and generates Decode stall/flush plus HALT.
//
// state   | meaning
// ST_RUN  | normal issue; Execute loads from Decode unless held or flushed
// ST_HALT | SYSTEM retired; Execute loads bubbles and Decode is stalled until resume
module pipelined_controller #(
   parameter int ALUCTRL_W = 4,
   parameter bit ENABLE_M  = 1'b1,
   parameter int MUL_LAT   = 3,
   parameter int DIV_LAT   = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 valid_d,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic [6:0]           funct7,
   input  logic                 zero_e,
   input  logic                 lt_e,
   input  logic                 ltu_e,
   input  logic                 ex_stall,
   input  logic                 resume,
   output logic                 valid_e,
   output logic                 memtoreg_e,
   output logic                 memwrite_e,
   output logic                 alusrc_e,
   output logic                 writesreg_e,
   output logic                 jump_e,
   output logic [ALUCTRL_W-1:0] alucontrol_e,
   output logic                 illegal_e,
   output logic                 brtaken_e,
   output logic                 flush_d,
   output logic                 stall_d,
   output logic                 halted
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MD   = 7'b0000001;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_MUL  = 4'd10;
   localparam logic [3:0] ALU_DIV  = 4'd11;
   localparam logic [3:0] ALU_REM  = 4'd12;

   typedef enum logic [1:0] {MC_NONE, MC_MUL, MC_DIV} mc_e;
   typedef enum logic {ST_RUN, ST_HALT} state_e;

   typedef struct packed {
      logic       valid;
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       writesreg;
      logic       jump;
      logic       illegal;
      logic       branch;
      logic       system;
      logic [2:0] br_type;
      logic [3:0] alu;
   } ctl_t;

   ctl_t             dec;
   mc_e              dec_mc;
   logic             dec_ill;
   logic [3:0]       alu_f3;
   ctl_t             ex_d, ex_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   state_e           state_d, state_q;
   logic             hold;
   logic             br_cond;

   always_comb begin
      alu_f3 = ALU_ADD;
      case (funct3)
         3'b000:  alu_f3 = ALU_ADD;
         3'b001:  alu_f3 = ALU_SLL;
         3'b010:  alu_f3 = ALU_SLT;
         3'b011:  alu_f3 = ALU_SLTU;
         3'b100:  alu_f3 = ALU_XOR;
         3'b101:  alu_f3 = ALU_SRL;
         3'b110:  alu_f3 = ALU_OR;
         default: alu_f3 = ALU_AND;
      endcase
   end

   always_comb begin
      dec     = '0;
      dec_mc  = MC_NONE;
      dec_ill = 1'b0;
      case (op)
         OP_R: begin
            dec.writesreg = 1'b1;
            if (funct7 == F7_MD) begin
               if (!ENABLE_M) begin
                  dec_ill = 1'b1;
               end else if (!funct3[2]) begin
                  dec.alu = ALU_MUL;
                  dec_mc  = MC_MUL;
               end else begin
                  dec.alu = funct3[1] ? ALU_REM : ALU_DIV;
                  dec_mc  = MC_DIV;
               end
            end else if (funct7 == F7_BASE) begin
               dec.alu = alu_f3;
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               dec.alu = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               dec.alu = ALU_SRA;
            end else begin
               dec_ill = 1'b1;
            end
         end
         OP_I: begin
            dec.alusrc    = 1'b1;
            dec.writesreg = 1'b1;
            dec.alu       = (funct3 == 3'b101 && funct7[5]) ? ALU_SRA : alu_f3;
         end
         OP_LOAD: begin
            dec.memtoreg  = 1'b1;
            dec.alusrc    = 1'b1;
            dec.writesreg = 1'b1;
         end
         OP_STORE: begin
            dec.memwrite = 1'b1;
            dec.alusrc   = 1'b1;
         end
         OP_BRANCH: begin
            if (funct3[2:1] == 2'b01) begin
               dec_ill = 1'b1;
            end else begin
               dec.branch  = 1'b1;
               dec.br_type = funct3;
               dec.alu     = ALU_SUB;
            end
         end
         OP_JAL: begin
            dec.jump      = 1'b1;
            dec.writesreg = 1'b1;
         end
         OP_JALR: begin
            dec.jump      = 1'b1;
            dec.writesreg = 1'b1;
            dec.alusrc    = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            dec.writesreg = 1'b1;
            dec.alusrc    = 1'b1;
         end
         OP_SYSTEM: dec.system = 1'b1;
         default:   dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec         = '0;
         dec.illegal = 1'b1;
         dec_mc      = MC_NONE;
      end
      dec.valid = 1'b1;
   end

   assign hold = (cnt_q != '0) | ex_stall;

   // Counter and Execute register advance together; ex_stall freezes both.
   always_comb begin
      ex_d  = ex_q;
      cnt_d = cnt_q;
      if (ex_stall) begin
         ex_d = ex_q;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else if (halted || flush_d || !valid_d) begin
         ex_d = '0;
      end else begin
         ex_d = dec;
         case (dec_mc)
            MC_MUL:  cnt_d = MUL_LOAD;
            MC_DIV:  cnt_d = DIV_LOAD;
            default: cnt_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         ex_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ex_q    <= ex_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (ex_q.valid && ex_q.system && !hold) state_d = ST_HALT;
         ST_HALT: if (resume) state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      br_cond = 1'b0;
      case (ex_q.br_type)
         3'b000:  br_cond = zero_e;
         3'b001:  br_cond = ~zero_e;
         3'b100:  br_cond = lt_e;
         3'b101:  br_cond = ~lt_e;
         3'b110:  br_cond = ltu_e;
         3'b111:  br_cond = ~ltu_e;
         default: br_cond = 1'b0;
      endcase
      halted    = (state_q == ST_HALT);
      brtaken_e = ex_q.valid & ex_q.branch & br_cond;
      flush_d   = brtaken_e | ex_q.jump;
      stall_d   = hold | halted;
   end

   assign valid_e      = ex_q.valid;
   assign memtoreg_e   = ex_q.memtoreg;
   assign memwrite_e   = ex_q.memwrite;
   assign alusrc_e     = ex_q.alusrc;
   assign writesreg_e  = ex_q.writesreg;
   assign jump_e       = ex_q.jump;
   assign illegal_e    = ex_q.illegal;
   assign alucontrol_e = ALUCTRL_W'(ex_q.alu);

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench for pipelined_controller: decode table, branches, multi-cycle stalls, HALT, reset.
module tb_pipelined_controller;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       valid_d = 1'b0;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic [6:0] funct7 = '0;
   logic       zero_e = 1'b0, lt_e = 1'b0, ltu_e = 1'b0;
   logic       ex_stall = 1'b0, resume = 1'b0;

   logic       valid_e, memtoreg_e, memwrite_e, alusrc_e, writesreg_e, jump_e;
   logic [3:0] alucontrol_e;
   logic       illegal_e, brtaken_e, flush_d, stall_d, halted;

   logic       n_valid_e, n_memtoreg_e, n_memwrite_e, n_alusrc_e, n_writesreg_e, n_jump_e;
   logic [3:0] n_alucontrol_e;
   logic       n_illegal_e, n_brtaken_e, n_flush_d, n_stall_d, n_halted;

   int total = 0;
   int bad   = 0;

   pipelined_controller u_dut (
      .clk(clk), .reset_n(reset_n), .valid_d(valid_d), .op(op), .funct3(funct3), .funct7(funct7),
      .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e), .ex_stall(ex_stall), .resume(resume),
      .valid_e(valid_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e), .alusrc_e(alusrc_e),
      .writesreg_e(writesreg_e), .jump_e(jump_e), .alucontrol_e(alucontrol_e),
      .illegal_e(illegal_e), .brtaken_e(brtaken_e), .flush_d(flush_d), .stall_d(stall_d),
      .halted(halted)
   );

   pipelined_controller #(.ENABLE_M(1'b0)) u_nom (
      .clk(clk), .reset_n(reset_n), .valid_d(valid_d), .op(op), .funct3(funct3), .funct7(funct7),
      .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e), .ex_stall(ex_stall), .resume(resume),
      .valid_e(n_valid_e), .memtoreg_e(n_memtoreg_e), .memwrite_e(n_memwrite_e),
      .alusrc_e(n_alusrc_e), .writesreg_e(n_writesreg_e), .jump_e(n_jump_e),
      .alucontrol_e(n_alucontrol_e), .illegal_e(n_illegal_e), .brtaken_e(n_brtaken_e),
      .flush_d(n_flush_d), .stall_d(n_stall_d), .halted(n_halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [6:0] ctl;   // {valid, memtoreg, memwrite, alusrc, writesreg, jump, illegal}
      logic [3:0] alu;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
      valid_d = v;
      op      = o;
      funct3  = f3;
      funct7  = f7;
   endtask

   function automatic logic [6:0] ctl_now();
      return {valid_e, memtoreg_e, memwrite_e, alusrc_e, writesreg_e, jump_e, illegal_e};
   endfunction

   task automatic run_branch(input string name, input logic [2:0] f3, input logic z,
                             input logic l, input logic lu, input logic exp);
      drive(1'b1, 7'b1100011, f3, 7'b0);
      step();
      zero_e = z; lt_e = l; ltu_e = lu;
      drive(1'b1, 7'b0110011, 3'b000, 7'b0);
      #1;
      chk({name, ".brtaken"}, 32'(brtaken_e), 32'(exp));
      chk({name, ".flush"},   32'(flush_d),   32'(exp));
      step();
      chk({name, ".next_valid"}, 32'(valid_e), 32'(!exp));
      drive(1'b0, 7'b0, 3'b0, 7'b0);
      zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      vecs[0]  = '{"add",   7'b0110011, 3'b000, 7'b0000000, 7'b1000100, 4'd0};
      vecs[1]  = '{"sub",   7'b0110011, 3'b000, 7'b0100000, 7'b1000100, 4'd1};
      vecs[2]  = '{"sra",   7'b0110011, 3'b101, 7'b0100000, 7'b1000100, 4'd7};
      vecs[3]  = '{"sltu",  7'b0110011, 3'b011, 7'b0000000, 7'b1000100, 4'd9};
      vecs[4]  = '{"or",    7'b0110011, 3'b110, 7'b0000000, 7'b1000100, 4'd3};
      vecs[5]  = '{"and",   7'b0110011, 3'b111, 7'b0000000, 7'b1000100, 4'd2};
      vecs[6]  = '{"slt",   7'b0110011, 3'b010, 7'b0000000, 7'b1000100, 4'd8};
      vecs[7]  = '{"addi",  7'b0010011, 3'b000, 7'b0101010, 7'b1001100, 4'd0};
      vecs[8]  = '{"srai",  7'b0010011, 3'b101, 7'b0100000, 7'b1001100, 4'd7};
      vecs[9]  = '{"srli",  7'b0010011, 3'b101, 7'b0000000, 7'b1001100, 4'd6};
      vecs[10] = '{"xori",  7'b0010011, 3'b100, 7'b0000000, 7'b1001100, 4'd4};
      vecs[11] = '{"slli",  7'b0010011, 3'b001, 7'b0000000, 7'b1001100, 4'd5};
      vecs[12] = '{"lw",    7'b0000011, 3'b010, 7'b0000000, 7'b1101100, 4'd0};
      vecs[13] = '{"sw",    7'b0100011, 3'b010, 7'b0000000, 7'b1011000, 4'd0};
      vecs[14] = '{"beq",   7'b1100011, 3'b000, 7'b0000000, 7'b1000000, 4'd1};
      vecs[15] = '{"jal",   7'b1101111, 3'b000, 7'b0000000, 7'b1000110, 4'd0};
      vecs[16] = '{"jalr",  7'b1100111, 3'b000, 7'b0000000, 7'b1001110, 4'd0};
      vecs[17] = '{"lui",   7'b0110111, 3'b000, 7'b0000000, 7'b1001100, 4'd0};
      vecs[18] = '{"auipc", 7'b0010111, 3'b000, 7'b0000000, 7'b1001100, 4'd0};
      vecs[19] = '{"badop", 7'b0001011, 3'b000, 7'b0000000, 7'b1000001, 4'd0};
      vecs[20] = '{"br011", 7'b1100011, 3'b011, 7'b0000000, 7'b1000001, 4'd0};

      // Reset state, with a live instruction presented during reset
      drive(1'b1, 7'b0110011, 3'b000, 7'b0);
      repeat (2) step();
      chk("reset.ctl",   32'(ctl_now()),    32'd0);
      chk("reset.alu",   32'(alucontrol_e), 32'd0);
      chk("reset.stall", 32'(stall_d),      32'd0);
      chk("reset.flush", 32'(flush_d),      32'd0);
      chk("reset.halt",  32'(halted),       32'd0);
      drive(1'b0, 7'b0, 3'b0, 7'b0);
      reset_n = 1'b1;
      step();

      for (int i = 0; i < NV; i++) begin
         drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7);
         step();
         chk({vecs[i].name, ".ctl"},   32'(ctl_now()),    32'(vecs[i].ctl));
         chk({vecs[i].name, ".alu"},   32'(alucontrol_e), 32'(vecs[i].alu));
         chk({vecs[i].name, ".stall"}, 32'(stall_d),      32'd0);
         drive(1'b0, 7'b0, 3'b0, 7'b0);
         step();
         chk({vecs[i].name, ".bubble"}, 32'(valid_e), 32'd0);
      end

      run_branch("beq_t",  3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
      run_branch("bne_nt", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      run_branch("blt_t",  3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
      run_branch("bge_nt", 3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
      run_branch("bltu_t", 3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
      run_branch("bgeu_t", 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
      run_branch("beq_nt", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Taken branch held by ex_stall keeps flushing
      drive(1'b1, 7'b1100011, 3'b000, 7'b0);
      step();
      zero_e = 1'b1; ex_stall = 1'b1;
      drive(1'b1, 7'b0110011, 3'b000, 7'b0);
      #1;
      chk("brhold.flush0", 32'(flush_d), 32'd1);
      step();
      chk("brhold.flush1", 32'(flush_d), 32'd1);
      step();
      ex_stall = 1'b0;
      #1;
      chk("brhold.flush2", 32'(flush_d), 32'd1);
      step();
      chk("brhold.bubble", 32'(valid_e), 32'd0);
      zero_e = 1'b0;
      drive(1'b0, 7'b0, 3'b0, 7'b0);
      step();

      // MUL: 2 stall cycles; ENABLE_M=0 instance sees an illegal op
      drive(1'b1, 7'b0110011, 3'b000, 7'b0000001);
      step();
      chk("mul.nom_ill",   32'(n_illegal_e),    32'd1);
      chk("mul.nom_valid", 32'(n_valid_e),      32'd1);
      chk("mul.nom_alu",   32'(n_alucontrol_e), 32'd0);
      chk("mul.nom_stall", 32'(n_stall_d),      32'd0);
      drive(1'b1, 7'b0110011, 3'b000, 7'b0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (!stall_d) break;
         n++;
         chk("mul.alu_held", 32'(alucontrol_e), 32'd10);
         step();
      end
      chk("mul.stall_cycles", 32'(n), 32'd2);
      chk("mul.alu_last",     32'(alucontrol_e), 32'd10);
      step();
      chk("mul.next_alu",   32'(alucontrol_e), 32'd0);
      chk("mul.next_valid", 32'(valid_e),      32'd1);
      drive(1'b0, 7'b0, 3'b0, 7'b0);
      step();

      // DIV with a 2-cycle ex_stall mid-count: 7 + 2 stall cycles
      drive(1'b1, 7'b0110011, 3'b100, 7'b0000001);
      step();
      drive(1'b0, 7'b0, 3'b0, 7'b0);
      chk("div.alu", 32'(alucontrol_e), 32'd11);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         ex_stall = (i == 2 || i == 3);
         #1;
         if (!stall_d) break;
         n++;
         step();
      end
      ex_stall = 1'b0;
      chk("div.stall_cycles", 32'(n), 32'd9);
      chk("div.alu_last",     32'(alucontrol_e), 32'd11);
      step();

      // ECALL -> HALT -> resume
      drive(1'b1, 7'b1110011, 3'b000, 7'b0);
      step();
      drive(1'b0, 7'b0, 3'b0, 7'b0);
      chk("ecall.valid",  32'(valid_e), 32'd1);
      chk("ecall.halt0",  32'(halted),  32'd0);
      chk("ecall.stall0", 32'(stall_d), 32'd0);
      step();
      chk("ecall.halt1",  32'(halted),  32'd1);
      chk("ecall.stall1", 32'(stall_d), 32'd1);
      step(); step();
      chk("ecall.halt3",  32'(halted),  32'd1);
      chk("ecall.bubble", 32'(valid_e), 32'd0);
      resume = 1'b1;
      #1;
      chk("ecall.halt_resume", 32'(halted), 32'd1);
      step();
      resume = 1'b0;
      chk("ecall.run",   32'(halted),  32'd0);
      chk("ecall.stall", 32'(stall_d), 32'd0);

      // Reset during a DIV count
      drive(1'b1, 7'b0110011, 3'b110, 7'b0000001);
      step();
      drive(1'b0, 7'b0, 3'b0, 7'b0);
      step();
      chk("rstdiv.pre_stall", 32'(stall_d), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rstdiv.stall", 32'(stall_d),      32'd0);
      chk("rstdiv.ctl",   32'(ctl_now()),    32'd0);
      chk("rstdiv.alu",   32'(alucontrol_e), 32'd0);
      reset_n = 1'b1;
      step();
      chk("rstdiv.post_stall", 32'(stall_d), 32'd0);
      chk("rstdiv.post_halt",  32'(halted),  32'd0);

      // Reset during HALT
      drive(1'b1, 7'b1110011, 3'b000, 7'b0);
      step();
      drive(1'b0, 7'b0, 3'b0, 7'b0);
      step();
      chk("rsthalt.pre", 32'(halted), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rsthalt.halt",  32'(halted),  32'd0);
      chk("rsthalt.stall", 32'(stall_d), 32'd0);
      reset_n = 1'b1;
      step();
      chk("rsthalt.post_halt",  32'(halted),  32'd0);
      chk("rsthalt.post_stall", 32'(stall_d), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
- Next-generation control unit for the RISC-V pipeline model.
- Fully decodes RV32I plus the optional M extension in the Decode stage and registers the control word into Execute.
- Resolves all six conditional branch types from Execute-stage ALU flags.
- Owns the Decode stall and flush generation for multi-cycle MUL/DIV, external Execute stalls and the SYSTEM pause/halt state.

Parameters:
ALUCTRL_W, 4, width of alucontrol_e; must be >= 4.
ENABLE_M, 1, 1 = decode the M extension (funct7=0000001 on op 0110011); 0 = treat it as illegal.
MUL_LAT, 3, Execute cycles for MUL* (>= 1).
DIV_LAT, 8, Execute cycles for DIV*/REM* (>= 1).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
valid_d  in  1  Decode holds a real instruction.
op  in  7  opcode in Decode.
funct3  in  3  funct3 in Decode.
funct7  in  7  funct7 in Decode.
zero_e  in  1  ALU zero flag, Execute instruction.
lt_e  in  1  ALU signed less-than flag, Execute.
ltu_e  in  1  ALU unsigned less-than flag, Execute.
ex_stall  in  1  external hold of Execute (memory wait).
resume  in  1  leave HALT.
valid_e, memtoreg_e, memwrite_e, alusrc_e, writesreg_e, jump_e  out  1 each  registered Execute control.
alucontrol_e  out  ALUCTRL_W  registered ALU operation.
illegal_e  out  1  registered; Execute holds an undecodable instruction.
brtaken_e  out  1  combinational branch-taken for the Execute instruction.
flush_d  out  1  combinational; squash the instruction in Decode (= brtaken_e | jump_e).
stall_d  out  1  combinational; hold PC and the Decode register.
halted  out  1  registered; FSM is in HALT.

Behaviour:
- Reset (reset_n=0, asynchronous): every registered output = 0; FSM = RUN; multi-cycle counter = 0.
- ALU encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, MUL 10, DIV 11, REM 12. Values are zero-extended to ALUCTRL_W. MULH* variants map to MUL, DIVU to DIV, REMU to REM.
- Decode by op:
  - 0110011 (R-type): writesreg = 1.
  - 0010011 (I-ALU): alusrc = 1, writesreg = 1; funct7 is used only for SRAI.
  - 0000011 (load): memtoreg = 1, alusrc = 1, writesreg = 1, ADD.
  - 0100011 (store): memwrite = 1, alusrc = 1, ADD.
  - 1100011 (branch): SUB; branch type = funct3 is stored.
  - 1101111 (JAL) and 1100111 (JALR): jump = 1, writesreg = 1. JALR also sets alusrc = 1.
  - 0110111 (LUI) and 0010111 (AUIPC): writesreg = 1, alusrc = 1, ADD.
  - 1110011 (SYSTEM): no writes; the FSM enters HALT the cycle after the instruction enters Execute.
  - Any other op, branch funct3 010/011, or M-extension encoding with ENABLE_M=0: all controls 0, illegal_e = 1, valid_e = 1.
- Execute register updates every cycle unless it is held.
  - It is held while stall_d is caused by the multi-cycle counter or by ex_stall.
  - If flush_d is high or valid_d is low, it loads a bubble (all controls 0, valid_e = 0).
- brtaken_e = valid_e & stored branch type, evaluated as:
  - beq: zero_e; bne: ~zero_e.
  - blt: lt_e; bge: ~lt_e.
  - bltu: ltu_e; bgeu: ~ltu_e.
  - 0 for non-branch instructions.
- Multi-cycle: when a MUL or DIV/REM class op is loaded into Execute, the counter loads LAT-1. While the counter is nonzero, stall_d = 1 and the counter decrements each cycle. ex_stall freezes the counter. LAT = 1 produces no stall.
- stall_d = (counter != 0) | ex_stall | halted.
- flush_d and a stall never conflict: a multi-cycle op is never a branch or jump. If ex_stall coincides with a taken branch, flush_d stays high for every held cycle.
- FSM:
  - RUN -> HALT on the cycle after a valid SYSTEM instruction is in Execute (and not held).
  - HALT: halted = 1; Execute loads bubbles.
  - HALT -> RUN when resume = 1; halted drops the next cycle.
  - resume is ignored in RUN.
- Reset mid-operation (during a counter run or in HALT) returns immediately to the reset state; no pending stall survives.

Test Plan:
- add x1,x2,x3 (op 0110011, f3 000, f7 0), valid_d = 1 -> next cycle: valid_e = 1, writesreg_e = 1, alusrc_e = 0, alucontrol_e = 0, stall_d = 0.
- beq with zero_e = 1 -> brtaken_e = 1 and flush_d = 1 in Execute. The next Execute value is a bubble. Repeat with bne and zero_e = 1 -> brtaken_e = 0.
- mul with MUL_LAT = 3 -> stall_d high for exactly 2 cycles; alucontrol_e = 10 held throughout. Same with ENABLE_M = 0 -> illegal_e = 1 and no stall.
- div with DIV_LAT = 8 plus ex_stall pulsed for 2 cycles mid-count -> stall_d high for 9 cycles in total.
- ecall -> halted = 1 one cycle after Execute; stall_d = 1 until resume is pulsed; halted = 0 the following cycle.
- Assert reset_n = 0 during a div count and during HALT -> all outputs 0 immediately; after release, stall_d = 0 and halted = 0.
